// File: rtl/eqn_rhs_generator_if.sv
// Stream bundle for eqn_rhs_generator: 12-word input stream and d1..d3 result handshake.
interface eqn_rhs_generator_if #(
  parameter int W  = 3,
  parameter int DW = 2*W+2
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;
  logic [DW-1:0] d3;
  logic          ovf;
  logic          busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, d1, d2, d3, ovf, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, d1, d2, d3, ovf, busy
  );
endinterface

// File: rtl/eqn_rhs_generator.sv
// Computes d = A*x for a 3x3 system streamed in as a1..c3,x1..x3, using one shared MAC.
//
// state   | meaning
// S_LOAD  | accepting the 12 input words
// S_CALC  | 9 MAC cycles, row-major over A
// S_LATCH | accumulators copied into the d/ovf output registers
// S_DONE  | result presented, waiting for out_ready
module eqn_rhs_generator #(
  parameter int W  = 3,
  parameter int DW = 2*W+2
) (
  input  logic                clk,
  input  logic                rst,
  eqn_rhs_generator_if.slave  bus
);
  localparam int PW = 2*W;
  localparam int SW = ((DW > PW) ? DW : PW) + 1;

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_LATCH, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_slot [12];
  logic [3:0]    r_count;
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [DW-1:0] r_acc [3];
  logic          r_ovf_acc;
  logic [DW-1:0] r_d1;
  logic [DW-1:0] r_d2;
  logic [DW-1:0] r_d3;
  logic          r_ovf;

  logic          w_accept;
  logic          w_mac_last;
  logic [3:0]    w_aidx;
  logic [3:0]    w_xidx;
  logic [PW-1:0] w_prod;
  logic [SW-1:0] w_sum;
  logic          w_sum_ovf;

  assign w_accept   = bus.in_valid && (r_state == S_LOAD);
  assign w_mac_last = (r_row == 2'd2) && (r_col == 2'd2);
  assign w_aidx     = 4'(r_row) * 4'd3 + 4'(r_col);
  assign w_xidx     = 4'd9 + 4'(r_col);
  assign w_prod     = PW'(r_slot[w_aidx]) * PW'(r_slot[w_xidx]);
  // Wide enough that any carry out of DW bits is visible, even when DW < 2W
  assign w_sum      = SW'(r_acc[r_row]) + SW'(w_prod);
  assign w_sum_ovf  = |w_sum[SW-1:DW];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_accept && (r_count == 4'd11)) w_state_nxt = S_CALC;
      S_CALC:  if (w_mac_last) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_slot[r_count] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_acc[0]  <= '0;
      r_acc[1]  <= '0;
      r_acc[2]  <= '0;
      r_ovf_acc <= 1'b0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_d3      <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + 4'd1;
            if (r_count == 4'd11) begin
              r_row     <= '0;
              r_col     <= '0;
              r_acc[0]  <= '0;
              r_acc[1]  <= '0;
              r_acc[2]  <= '0;
              r_ovf_acc <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_acc[r_row] <= w_sum[DW-1:0];
          if (w_sum_ovf) r_ovf_acc <= 1'b1;
          if (r_col == 2'd2) begin
            r_col <= '0;
            r_row <= r_row + 2'd1;
          end else begin
            r_col <= r_col + 2'd1;
          end
        end
        S_LATCH: begin
          r_d1  <= r_acc[0];
          r_d2  <= r_acc[1];
          r_d3  <= r_acc[2];
          r_ovf <= r_ovf_acc;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_ovf   <= 1'b0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_LOAD);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_LOAD);
  assign bus.d1        = r_d1;
  assign bus.d2        = r_d2;
  assign bus.d3        = r_d3;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_eqn_rhs_generator.sv
// Directed bench for eqn_rhs_generator: a DW=8 instance plus a DW=7 instance fed the same stream.
module tb_eqn_rhs_generator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eqn_rhs_generator_if #(.W(3), .DW(8)) bus8 ();
  eqn_rhs_generator_if #(.W(3), .DW(7)) bus7 ();

  assign bus7.in_valid  = bus8.in_valid;
  assign bus7.in_data   = bus8.in_data;
  assign bus7.out_ready = bus8.out_ready;

  eqn_rhs_generator #(.W(3), .DW(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus8.slave));
  eqn_rhs_generator #(.W(3), .DW(7)) u_dut7 (.clk(clk), .rst(rst), .bus(bus7.slave));

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] vec [12];
  int bad;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sys(input bit gaps, output int rdy_bad);
    rdy_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (gaps) begin
        bus8.in_valid = 1'b0;
        bus8.in_data  = ~vec[i];
        if (bus8.in_ready !== 1'b1) rdy_bad++;
        tick();
      end
      bus8.in_valid = 1'b1;
      bus8.in_data  = vec[i];
      if (bus8.in_ready !== 1'b1) rdy_bad++;
      tick();
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 10);
  endtask

  task automatic chk_d(input string tag, input int e1, input int e2, input int e3, input int eo);
    chk({tag, "_d1"}, bus8.d1, e1);
    chk({tag, "_d2"}, bus8.d2, e2);
    chk({tag, "_d3"}, bus8.d3, e3);
    chk({tag, "_ovf"}, bus8.ovf, eo);
  endtask

  task automatic accept();
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", bus8.in_ready, 1);
    chk("rst_out_valid", bus8.out_valid, 0);
    chk("rst_busy", bus8.busy, 0);
    chk_d("rst", 0, 0, 0, 0);

    // identity A, x=(1,2,3)
    vec = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
    send_sys(1'b0, bad);
    chk("c1_busy_calc", bus8.busy, 1);
    chk("c1_in_ready_calc", bus8.in_ready, 0);
    get_result("c1");
    chk_d("c1", 1, 2, 3, 0);
    chk("c1_in_ready_done", bus8.in_ready, 0);
    accept();
    chk("c1_out_valid_after", bus8.out_valid, 0);
    chk("c1_in_ready_after", bus8.in_ready, 1);

    vec = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd1, 3'd1, 3'd1};
    send_sys(1'b0, bad);
    get_result("c2a");
    chk_d("c2a", 6, 6, 6, 0);
    accept();
    vec = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1};
    send_sys(1'b0, bad);
    get_result("c2b");
    chk_d("c2b", 3, 3, 0, 0);
    accept();

    for (int i = 0; i < 12; i++) vec[i] = 3'd7;
    send_sys(1'b0, bad);
    get_result("c3");
    chk_d("c3", 147, 147, 147, 0);
    chk("c3_dw7_valid", bus7.out_valid, 1);
    chk("c3_dw7_d1", bus7.d1, 19);
    chk("c3_dw7_d2", bus7.d2, 19);
    chk("c3_dw7_d3", bus7.d3, 19);
    chk("c3_dw7_ovf", bus7.ovf, 1);
    accept();
    chk("c3_dw7_ovf_clr", bus7.ovf, 0);

    // gapped stream, inverted junk on idle cycles
    vec = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd1, 3'd1, 3'd1};
    send_sys(1'b1, bad);
    chk("c4_in_ready_load", bad, 0);
    get_result("c4");
    chk_d("c4", 6, 6, 6, 0);
    accept();

    // held result, in_valid asserted in DONE must be ignored
    vec = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd1};
    send_sys(1'b0, bad);
    get_result("c5");
    chk_d("c5", 11, 29, 15, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_data  = 3'd7;
      tick();
      if (bus8.out_valid !== 1'b1 || bus8.d1 !== 8'd11 || bus8.d2 !== 8'd29 ||
          bus8.d3 !== 8'd15 || bus8.ovf !== 1'b0 || bus8.in_ready !== 1'b0) bad++;
    end
    chk("c5_hold_stable", bad, 0);
    accept();
    bus8.in_valid = 1'b0;
    chk("c5_out_valid_after", bus8.out_valid, 0);
    chk("c5_d1_kept", bus8.d1, 11);
    vec = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd7, 3'd0, 3'd1};
    send_sys(1'b0, bad);
    get_result("c5b");
    chk_d("c5b", 56, 0, 8, 0);
    accept();

    // reset during CALC cycle 4
    vec = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
    send_sys(1'b0, bad);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c6_in_ready", bus8.in_ready, 1);
    chk("c6_busy", bus8.busy, 0);
    chk_d("c6_rst", 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus8.out_valid !== 1'b0) bad++;
    end
    chk("c6_no_out_valid", bad, 0);
    vec = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    send_sys(1'b0, bad);
    get_result("c6b");
    chk_d("c6b", 6, 15, 8, 0);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
